// File: rtl/kmp_dispatch_sched_if.sv
// Host job/result handshake plus the per-PE control and result buses of the
// KMP dispatch scheduler, bundled so the scheduler and its environment share one port.
interface kmp_dispatch_sched_if #(
    parameter int unsigned NUM_PE  = 4,
    parameter int unsigned LOG2_PE = 2,
    parameter int unsigned SW      = 6,
    parameter int unsigned PW      = 3
);
    logic                   job_valid;
    logic                   job_ready;
    logic [SW-1:0]          str_last_idx;
    logic [PW-1:0]          pat_last_idx;

    logic                   res_valid;
    logic                   res_ready;
    logic                   res_match;
    logic [SW-1:0]          res_idx;
    logic [LOG2_PE-1:0]     res_pe;

    logic [NUM_PE-1:0]      pe_input_valid;
    logic [NUM_PE*SW-1:0]   pe_start_idx;
    logic [NUM_PE*SW-1:0]   pe_process_2idx;
    logic [PW-1:0]          pe_pat_last_idx;
    logic [NUM_PE-1:0]      pe_output_valid;
    logic [NUM_PE-1:0]      pe_match;
    logic [NUM_PE*SW-1:0]   pe_match_idx;

    // Scheduler side
    modport slave (
        input  job_valid, str_last_idx, pat_last_idx, res_ready,
               pe_output_valid, pe_match, pe_match_idx,
        output job_ready, res_valid, res_match, res_idx, res_pe,
               pe_input_valid, pe_start_idx, pe_process_2idx, pe_pat_last_idx
    );

    // Host and PE-array side
    modport master (
        output job_valid, str_last_idx, pat_last_idx, res_ready,
               pe_output_valid, pe_match, pe_match_idx,
        input  job_ready, res_valid, res_match, res_idx, res_pe,
               pe_input_valid, pe_start_idx, pe_process_2idx, pe_pat_last_idx
    );
endinterface

// File: rtl/kmp_dispatch_sched.sv
// Splits one string-match job into NUM_PE overlapping segments, launches the
// KMP PEs, gathers their results and reports the earliest match.
module kmp_dispatch_sched #(
    parameter int unsigned NUM_PE  = 4,
    parameter int unsigned LOG2_PE = 2,
    parameter int unsigned SW      = 6,
    parameter int unsigned PW      = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    kmp_dispatch_sched_if.slave  bus
);
    localparam int unsigned AW = SW + 1;

    typedef enum logic [2:0] {IDLE, CALC, LAUNCH, WAIT, DRAIN, DONE} state_t;

    state_t              r_state;
    logic [SW-1:0]       r_s;
    logic [PW-1:0]       r_p;
    logic [NUM_PE-1:0]   r_active;
    logic [NUM_PE-1:0]   r_done;
    logic [NUM_PE-1:0]   r_match;
    logic [NUM_PE-1:0]   r_iv;
    logic [SW-1:0]       r_start [NUM_PE];
    logic [SW-1:0]       r_end   [NUM_PE];
    logic [SW-1:0]       r_midx  [NUM_PE];
    logic                r_drain;
    logic                r_job_ready;
    logic                r_res_valid;
    logic                r_res_match;
    logic [SW-1:0]       r_res_idx;
    logic [LOG2_PE-1:0]  r_res_pe;

    logic [AW-1:0]       w_s, w_p, w_len, w_stride;
    logic [AW-1:0]       w_start   [NUM_PE];
    logic [AW-1:0]       w_end_raw [NUM_PE];
    logic [SW-1:0]       w_end     [NUM_PE];
    logic [NUM_PE-1:0]   w_active;
    logic [NUM_PE-1:0]   w_new;
    logic [NUM_PE-1:0]   w_done_nxt;
    logic                w_sel_found;
    logic [LOG2_PE-1:0]  w_sel_pe;
    logic [SW-1:0]       w_sel_idx;

    // Segment split: each segment overlaps the next by P so no match straddles a gap
    always_comb begin
        w_s      = AW'(r_s);
        w_p      = AW'(r_p);
        w_len    = w_s + AW'(1);
        w_stride = (w_len + AW'(NUM_PE - 1)) >> LOG2_PE;
        for (int k = 0; k < NUM_PE; k++) begin
            w_start[k]   = AW'(k) * w_stride;
            w_end_raw[k] = w_start[k] + w_stride - AW'(1) + w_p;
            w_end[k]     = (w_end_raw[k] > w_s) ? r_s : SW'(w_end_raw[k]);
            w_active[k]  = (w_p <= w_s) && (w_start[k] <= (w_s - w_p));
        end
    end

    // Only the first pe_output_valid of each PE counts; later ones are stale
    always_comb begin
        w_new      = bus.pe_output_valid & ~r_done;
        w_done_nxt = r_done | bus.pe_output_valid;
    end

    // Lowest-index matching PE holds the earliest match in the string
    always_comb begin
        w_sel_found = 1'b0;
        w_sel_pe    = '0;
        w_sel_idx   = '0;
        for (int k = NUM_PE - 1; k >= 0; k--) begin
            if (r_match[k]) begin
                w_sel_found = 1'b1;
                w_sel_pe    = LOG2_PE'(k);
                w_sel_idx   = r_midx[k];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_s         <= '0;
            r_p         <= '0;
            r_active    <= '0;
            r_done      <= '0;
            r_match     <= '0;
            r_iv        <= '0;
            r_drain     <= 1'b0;
            r_job_ready <= 1'b1;
            r_res_valid <= 1'b0;
            r_res_match <= 1'b0;
            r_res_idx   <= '0;
            r_res_pe    <= '0;
            for (int k = 0; k < NUM_PE; k++) begin
                r_start[k] <= '0;
                r_end[k]   <= '0;
                r_midx[k]  <= '0;
            end
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.job_valid) begin
                        r_s         <= bus.str_last_idx;
                        r_p         <= bus.pat_last_idx;
                        r_match     <= '0;
                        r_done      <= '0;
                        r_active    <= '0;
                        r_job_ready <= 1'b0;
                        r_state     <= CALC;
                    end
                end
                CALC: begin
                    r_active <= w_active;
                    r_done   <= ~w_active;
                    r_drain  <= 1'b0;
                    for (int k = 0; k < NUM_PE; k++) begin
                        r_start[k] <= w_active[k] ? SW'(w_start[k]) : '0;
                        r_end[k]   <= w_active[k] ? w_end[k] : '0;
                        r_midx[k]  <= '0;
                    end
                    r_state <= (|w_active) ? LAUNCH : DRAIN;
                end
                LAUNCH: begin
                    r_iv    <= r_active;
                    r_state <= WAIT;
                end
                WAIT: begin
                    for (int k = 0; k < NUM_PE; k++) begin
                        if (w_new[k]) begin
                            r_match[k] <= bus.pe_match[k];
                            r_midx[k]  <= bus.pe_match_idx[k*SW +: SW];
                        end
                    end
                    r_done <= w_done_nxt;
                    r_iv   <= r_iv & ~w_new;
                    if (&w_done_nxt) begin
                        r_drain <= 1'b0;
                        r_state <= DRAIN;
                    end
                end
                DRAIN: begin
                    r_drain <= 1'b1;
                    if (r_drain) begin
                        r_res_valid <= 1'b1;
                        r_res_match <= w_sel_found;
                        r_res_idx   <= w_sel_idx;
                        r_res_pe    <= w_sel_pe;
                        r_state     <= DONE;
                    end
                end
                DONE: begin
                    if (bus.res_ready) begin
                        r_res_valid <= 1'b0;
                        r_res_match <= 1'b0;
                        r_res_idx   <= '0;
                        r_res_pe    <= '0;
                        r_job_ready <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.job_ready       = r_job_ready;
    assign bus.res_valid       = r_res_valid;
    assign bus.res_match       = r_res_match;
    assign bus.res_idx         = r_res_idx;
    assign bus.res_pe          = r_res_pe;
    assign bus.pe_input_valid  = r_iv;
    assign bus.pe_pat_last_idx = r_p;

    for (genvar g = 0; g < NUM_PE; g++) begin : g_lane
        assign bus.pe_start_idx[g*SW +: SW]    = r_start[g];
        assign bus.pe_process_2idx[g*SW +: SW] = r_end[g];
    end
endmodule

// File: tb/tb_kmp_dispatch_sched.sv
// Directed bench for kmp_dispatch_sched: host jobs, scripted PE responses,
// hand-computed segment indices and results.
module tb_kmp_dispatch_sched;
    localparam int unsigned NUM_PE  = 4;
    localparam int unsigned LOG2_PE = 2;
    localparam int unsigned SW      = 6;
    localparam int unsigned PW      = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    kmp_dispatch_sched_if #(.NUM_PE(NUM_PE), .LOG2_PE(LOG2_PE), .SW(SW), .PW(PW)) bus ();

    kmp_dispatch_sched #(.NUM_PE(NUM_PE), .LOG2_PE(LOG2_PE), .SW(SW), .PW(PW)) u_dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [SW-1:0] lane(input logic [NUM_PE*SW-1:0] v, input int k);
        return v[k*SW +: SW];
    endfunction

    task automatic set_pe(input logic [NUM_PE-1:0] ov, input logic [NUM_PE-1:0] m,
                          input int i0, input int i1, input int i2, input int i3);
        bus.pe_output_valid = ov;
        bus.pe_match        = m;
        bus.pe_match_idx    = {SW'(i3), SW'(i2), SW'(i1), SW'(i0)};
    endtask

    // Accept edge, then CALC and LAUNCH edges: on return the PEs are launched
    task automatic start_job(input int s, input int p);
        bus.job_valid    = 1'b1;
        bus.str_last_idx = SW'(s);
        bus.pat_last_idx = PW'(p);
        tick();
        bus.job_valid = 1'b0;
        check_eq("job_ready_low_after_accept", 32'(bus.job_ready), 0);
        tick();
        tick();
    endtask

    task automatic check_lanes(input string tag, input int s0, input int s1, input int s2, input int s3,
                               input int e0, input int e1, input int e2, input int e3, input int nl);
        int sv [4];
        int ev [4];
        sv = '{s0, s1, s2, s3};
        ev = '{e0, e1, e2, e3};
        for (int k = 0; k < nl; k++) begin
            check_eq({tag, "_start"}, 32'(lane(bus.pe_start_idx, k)), 32'(sv[k]));
            check_eq({tag, "_end"},   32'(lane(bus.pe_process_2idx, k)), 32'(ev[k]));
        end
    endtask

    task automatic wait_res(input string tag, input int m, input int idx, input int pe);
        int n;
        n = 0;
        while (!bus.res_valid && n < 20) begin
            tick();
            n++;
        end
        check_eq({tag, "_res_valid"}, 32'(bus.res_valid), 1);
        check_eq({tag, "_res_match"}, 32'(bus.res_match), 32'(m));
        check_eq({tag, "_res_idx"},   32'(bus.res_idx),   32'(idx));
        check_eq({tag, "_res_pe"},    32'(bus.res_pe),    32'(pe));
    endtask

    task automatic handshake(input string tag);
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;
        check_eq({tag, "_hs_res_valid"}, 32'(bus.res_valid), 0);
        check_eq({tag, "_hs_job_ready"}, 32'(bus.job_ready), 1);
        check_eq({tag, "_hs_res_idx"},   32'(bus.res_idx),   0);
    endtask

    task automatic job_31_3(input string tag);
        start_job(31, 3);
        check_eq({tag, "_iv"},  32'(bus.pe_input_valid), 32'h f);
        check_eq({tag, "_pat"}, 32'(bus.pe_pat_last_idx), 3);
        check_lanes(tag, 0, 8, 16, 24, 10, 18, 26, 31, 4);
        set_pe(4'b1111, 4'b1100, 0, 0, 20, 27);
        tick();
        set_pe(4'b0000, 4'b0000, 0, 0, 0, 0);
        check_eq({tag, "_iv_cleared"}, 32'(bus.pe_input_valid), 0);
        wait_res(tag, 1, 20, 2);
        handshake(tag);
    endtask

    initial begin
        bus.job_valid    = 1'b0;
        bus.str_last_idx = '0;
        bus.pat_last_idx = '0;
        bus.res_ready    = 1'b0;
        set_pe('0, '0, 0, 0, 0, 0);
        #12;
        check_eq("rst_job_ready", 32'(bus.job_ready), 1);
        check_eq("rst_res_valid", 32'(bus.res_valid), 0);
        check_eq("rst_res_idx",   32'(bus.res_idx), 0);
        check_eq("rst_iv",        32'(bus.pe_input_valid), 0);
        check_eq("rst_start",     32'(bus.pe_start_idx), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // All four PEs, PE2 and PE3 both match: lowest PE wins
        job_31_3("t1");

        // PE3 segment starts past S-P and is never launched
        start_job(9, 2);
        check_eq("t2_iv", 32'(bus.pe_input_valid), 32'b0111);
        check_lanes("t2", 0, 3, 6, 0, 4, 7, 9, 0, 3);
        set_pe(4'b0111, 4'b0000, 0, 0, 0, 0);
        tick();
        set_pe('0, '0, 0, 0, 0, 0);
        wait_res("t2", 0, 0, 0);
        handshake("t2");

        // Pattern longer than string: straight to DRAIN, result in the 4th cycle
        bus.job_valid    = 1'b1;
        bus.str_last_idx = SW'(5);
        bus.pat_last_idx = PW'(7);
        tick();
        bus.job_valid = 1'b0;
        tick();
        check_eq("t3_c1_res_valid", 32'(bus.res_valid), 0);
        check_eq("t3_c1_iv",        32'(bus.pe_input_valid), 0);
        tick();
        check_eq("t3_c2_res_valid", 32'(bus.res_valid), 0);
        tick();
        check_eq("t3_c3_res_valid", 32'(bus.res_valid), 1);
        check_eq("t3_res_match",    32'(bus.res_match), 0);
        check_eq("t3_iv",           32'(bus.pe_input_valid), 0);
        handshake("t3");

        // Out-of-order completion with a stale PE3 valid held high
        start_job(31, 3);
        set_pe(4'b1000, 4'b1000, 0, 0, 0, 27);
        tick();
        check_eq("t4_iv_pe3_fell", 32'(bus.pe_input_valid), 32'b0111);
        tick();
        set_pe(4'b1101, 4'b1000, 0, 0, 0, 27);
        tick();
        check_eq("t4_iv_pe02_fell", 32'(bus.pe_input_valid), 32'b0010);
        set_pe(4'b1000, 4'b1000, 0, 0, 0, 27);
        tick();
        tick();
        set_pe(4'b1010, 4'b1010, 0, 12, 0, 27);
        tick();
        set_pe('0, '0, 0, 0, 0, 0);
        check_eq("t4_iv_all_fell", 32'(bus.pe_input_valid), 0);
        wait_res("t4", 1, 12, 1);
        handshake("t4");

        // Stale valid with a different index must not overwrite PE3's result
        start_job(31, 3);
        set_pe(4'b1000, 4'b1000, 0, 0, 0, 27);
        tick();
        set_pe(4'b1000, 4'b1000, 0, 0, 0, 30);
        tick();
        set_pe(4'b1111, 4'b1000, 0, 0, 0, 30);
        tick();
        set_pe('0, '0, 0, 0, 0, 0);
        wait_res("t5", 1, 27, 3);
        // Result held while the host stalls
        for (int i = 0; i < 10; i++) begin
            tick();
            check_eq("t5_hold_res_valid", 32'(bus.res_valid), 1);
            check_eq("t5_hold_res_idx",   32'(bus.res_idx), 27);
            check_eq("t5_hold_job_ready", 32'(bus.job_ready), 0);
        end
        handshake("t5");

        // Asynchronous reset while PEs are busy
        start_job(31, 3);
        check_eq("t6_iv_before_rst", 32'(bus.pe_input_valid), 32'h f);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("t6_rst_iv",        32'(bus.pe_input_valid), 0);
        check_eq("t6_rst_res_valid", 32'(bus.res_valid), 0);
        check_eq("t6_rst_job_ready", 32'(bus.job_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        job_31_3("t6_after");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end
endmodule

// File: doc/kmp_dispatch_sched.md
Name: kmp_dispatch_sched

Overview:
- Scheduler for the parallel string-match engine. It owns NUM_PE KMP processing elements and accepts one match job at a time from the host.
- It splits the string index range into NUM_PE overlapping segments and drives each PE's start index, end index and valid handshake.
- It collects the per-PE results and reports the earliest match in the string.
- The string, pattern and failure-function buses run straight from the buffers to the PEs and do not pass through this block.

Parameters:
- NUM_PE, 4, number of PEs; must be a power of 2 and at least 2.
- LOG2_PE, 2, log2(NUM_PE).
- SW, 6, string index width; maximum string length is 2^SW.
- PW, 3, pattern index width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- job_valid  in  1  host offers a job.
- job_ready  out  1  block can accept a job.
- str_last_idx  in  SW  last valid string index; sampled when a job is accepted.
- pat_last_idx  in  PW  last valid pattern index; sampled when a job is accepted.
- res_valid  out  1  result available; held until accepted.
- res_ready  in  1  host accepts the result.
- res_match  out  1  1 = a match was found.
- res_idx  out  SW  string index where the earliest match starts; 0 when there is no match.
- res_pe  out  LOG2_PE  PE that supplied the result; 0 when there is no match.
- pe_input_valid  out  NUM_PE  per-PE job valid; level signal.
- pe_start_idx  out  NUM_PE*SW  per-PE first string index; PE k occupies bits [k*SW +: SW].
- pe_process_2idx  out  NUM_PE*SW  per-PE last string index to examine.
- pe_pat_last_idx  out  PW  pattern last index, broadcast to all PEs.
- pe_output_valid  in  NUM_PE  per-PE result valid.
- pe_match  in  NUM_PE  per-PE match flag.
- pe_match_idx  in  NUM_PE*SW  per-PE match start index.

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE.
  - job_ready=1; res_valid, res_match, res_idx, res_pe are all 0.
  - pe_input_valid=0; all latched indices are 0.
- States: IDLE, CALC, LAUNCH, WAIT, DRAIN, DONE.
- IDLE:
  - job_ready=1. On job_valid=1, latch str_last_idx (S) and pat_last_idx (P) and go to CALC.
  - job_ready=0 in every other state.
- CALC (1 cycle), using SW+1-bit arithmetic:
  - L = S+1; stride = (L+NUM_PE-1) >> LOG2_PE.
  - start_k = k*stride; end_k = min(start_k + stride - 1 + P, S).
  - PE k is active iff P <= S and start_k <= S-P.
  - Inactive PEs are marked complete with no match.
  - If no PE is active, go to DRAIN; otherwise go to LAUNCH.
- LAUNCH (1 cycle): drive pe_start_idx and pe_process_2idx, and set pe_input_valid[k]=1 for each active PE. Then go to WAIT.
- WAIT:
  - Indices stay stable while any pe_input_valid is 1.
  - When pe_output_valid[k]=1 and PE k is not yet complete: latch pe_match[k] and pe_match_idx[k], mark PE k complete, and clear pe_input_valid[k] on the next edge.
  - pe_output_valid is ignored for PEs already complete.
  - Any number of PEs may complete in the same cycle; completion order is arbitrary.
  - When all PEs are complete, go to DRAIN.
- DRAIN (exactly 2 cycles):
  - Gives the PEs time to return to idle.
  - Result select: the lowest k with a latched match wins. res_match=1, res_idx=latched idx of PE k, res_pe=k.
  - The lowest-k rule is exact: each segment's first match always precedes any match found by a higher-index PE.
  - With no match: res_match=0, res_idx=0, res_pe=0.
- DONE:
  - res_valid=1 and the result is held stable.
  - When res_valid and res_ready are both 1 on an edge: res_valid goes to 0, res_* fields clear, and the state returns to IDLE.
- A new job cannot be accepted earlier than the cycle after the result handshake.
- The block has no timeout; the host applies reset to abort.
- Reset mid-job: pe_input_valid drops to 0 asynchronously; the PEs are then reset by the system reset.

Test Plan:
- S=31, P=3, NUM_PE=4 → stride 8; starts 0/8/16/24; ends 10/18/26/31. PE2 matches at 20, PE3 matches at 27 → res_match=1, res_idx=20, res_pe=2.
- S=9, P=2 → stride 3; starts 0/3/6; ends 4/7/9; PE3 is not launched (pe_input_valid[3] stays 0). No matches → res_match=0, res_idx=0.
- S=5, P=7 → no PE launched. res_valid rises 4 cycles after job acceptance (CALC, DRAIN×2, DONE); res_match=0.
- Out-of-order completion: PE3 completes first with match 27, PE1 completes 5 cycles later with match 12. Required:
  - res_idx=12, res_pe=1.
  - pe_input_valid[3] falls one cycle after its pe_output_valid.
  - A stale pe_output_valid[3] held high is ignored.
- res_ready held at 0 for 10 cycles → res_valid and the result stay stable and job_ready stays 0. Raise res_ready → res_valid=0 and job_ready=1 on the next cycle.
- Assert reset during WAIT → pe_input_valid=0, res_valid=0, job_ready=1 immediately. The next job completes correctly.
